fc_layer2_spike_scheduler: RTL
==============================

// Module: fc_layer2_spike_scheduler
// PURPOSE
// Ping-pong spike-index buffer and issue sequencer in front of the layer-2 FC PE.
// Layer-1 writes the indices of active input channels for one frame into a free bank.
// The block then replays that list once per output channel (OUTPUT_CHANNEL_NUM passes),
// one index per cycle on s_index_ram/s_index_valid, with addr_most = spike count - 1.
// It frees the bank after the PE pipeline has drained. The write side fills the other bank meanwhile.
// PARAMETERS
// INPUT_CHANNEL_NUM   128  max spikes per frame = bank depth; cnt width clog2(INPUT_CHANNEL_NUM+1)
// OUTPUT_CHANNEL_NUM  256  replay passes per frame (PE output channels)
// PIPE_LAT            4    cycles from last s_index_valid to last PE mp_ready (drain wait)
// PORTS
// clk             in   1               system clock
// rstn            in   1               synchronous, active-high reset (asserted = 1)
// spk_wr_en       in   1               write spk_wr_idx into current fill bank
// spk_wr_idx      in   `SYNAPSE_INDEX  input-channel index of a spike
// spk_frame_end   in   1               closes fill bank (frame complete), 1-cycle pulse
// spk_wr_ready    out  1               a fill bank is available
// s_index_ram     out  `SYNAPSE_INDEX  index to PE
// addr_most       out  `CONV1_ADDR     spike count of active frame - 1 (held stable during ISSUE)
// s_index_valid   out  1               s_index_ram valid this cycle
// frame_done      out  1               1-cycle pulse when a bank is released
// busy            out  1               FSM not in IDLE
// spk_overflow    out  1               sticky: write dropped (bank full or no free bank)
// BEHAVIOUR
// - Every reg/output resets to 0. Both banks become empty/free, fill bank = 0, spk_wr_ready=1 the cycle after rstn deasserts.
// - Reset mid-operation aborts the frame: no further s_index_valid, no frame_done.
// - Write side: spk_wr_en && spk_wr_ready && cnt<INPUT_CHANNEL_NUM -> mem[fill][cnt]<=idx, cnt++.
// - Otherwise the write is dropped and spk_overflow<=1.
// - spk_frame_end marks fill bank FULL and toggles the fill pointer. spk_wr_en in the same cycle is
//   written first and belongs to the closing frame.
// - spk_wr_ready = fill bank not FULL.
// - FSM IDLE -> ISSUE when a FULL bank exists. Take the oldest bank (the bank not being filled).
// - IDLE -> ISSUE: latch rd_bank and N. Drive addr_most=N-1.
// - If N==0: go IDLE -> RELEASE directly. No s_index_valid is issued.
// - ISSUE: sync bank read, 1-cycle latency. s_index_valid is registered and asserts 1 cycle after
//   the first read address; it stays high for N*OUTPUT_CHANNEL_NUM contiguous cycles.
// - Order is idx 0..N-1 for ch 0, then for ch 1, and so on. idx_cnt wraps N-1 -> 0 and increments ch_cnt.
// - On idx_cnt==N-1 && ch_cnt==OUTPUT_CHANNEL_NUM-1, go to DRAIN.
// - DRAIN: count PIPE_LAT cycles after the last s_index_valid, then go to RELEASE.
// - RELEASE (1 cycle): bank -> empty/free, cnt=0, frame_done=1, then IDLE.
// - The write side may reuse the released bank the next cycle.
// - Back-to-back frames: if the other bank is FULL at RELEASE, IDLE lasts exactly 1 cycle.
// - Simultaneous RELEASE and spk_frame_end on different banks are both honoured in the same cycle.
// - Total s_index_valid count per frame = N*OUTPUT_CHANNEL_NUM exactly. No gaps, no duplicates.
// - s_index_ram and addr_most stay at their last values when s_index_valid=0.
// - addr_most is zero-extended from the cnt width.
// STRUCTURE
// - Shared package/define.vh additions:
//   - FSM encodings SCH_IDLE/SCH_ISSUE/SCH_DRAIN/SCH_RELEASE (2 bits)
//   - `SPK_CNT_W
// - Sub-module spike_pingpong_buf:
//   - 2 x INPUT_CHANNEL_NUM x `SYNAPSE_INDEX storage, one write port, one sync read port
//   - per-bank cnt and FULL flags
// - The FSM and counters stay in the top module.
// TESTING
// 1. Reset, write idx 5,9,77 + frame_end -> addr_most=2; s_index_valid for 768 cycles.
//    Sequence is 5,9,77 repeated 256x; frame_done exactly PIPE_LAT+1 cycles after the last valid.
// 2. frame_end with no writes (N=0) -> zero s_index_valid; frame_done 2 cycles later.
// 3. 129 writes into one bank -> first 128 stored, spk_overflow=1 sticky; addr_most=127.
// 4. Fill bank0 and bank1 while bank0 is issuing -> spk_wr_ready=0.
//    A write now -> dropped, spk_overflow=1.
//    After bank0 frame_done, bank1 issues after 1 IDLE cycle.
// 5. spk_wr_en + spk_frame_end in the same cycle (idx 3, after idx 1) -> frame N=2, order 1,3.
// 6. rstn=1 mid-ISSUE -> s_index_valid=0 next cycle; no frame_done; banks empty; spk_wr_ready=1.

Source files
------------

// File: rtl/fc_layer2_spike_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// fc_layer2_spike_scheduler_pkg
// Shared widths and FSM encoding for the layer-2 FC spike scheduler.
//   SYNAPSE_INDEX_W : width of an input-channel (synapse) index
//   CONV1_ADDR_W    : width of the addr_most bus towards the PE
//   SPK_DEPTH       : default bank depth (max spikes per frame)
//   SPK_CNT_W       : width of a per-bank spike counter (0..SPK_DEPTH)
// ---------------------------------------------------------------------------
package fc_layer2_spike_scheduler_pkg;

    localparam int SYNAPSE_INDEX_W = 7;
    localparam int CONV1_ADDR_W    = 10;
    localparam int SPK_DEPTH       = 128;
    localparam int SPK_CNT_W       = $clog2(SPK_DEPTH + 1);

    typedef enum logic [1:0] {
        SCH_IDLE    = 2'd0,
        SCH_ISSUE   = 2'd1,
        SCH_DRAIN   = 2'd2,
        SCH_RELEASE = 2'd3
    } sch_state_e;

endpackage

// File: rtl/spike_pingpong_buf.sv
// ---------------------------------------------------------------------------
// spike_pingpong_buf
// Two-bank spike-index store. One write port fills the current fill bank,
// one synchronous read port (1-cycle latency) replays a closed bank.
// Ports:
//   clk, rstn            clock, synchronous active-high reset
//   wr_en, wr_idx        spike write request and index
//   frame_end            close the fill bank and switch to the other one
//   rel_en, rel_bank     release (empty + free) a bank
//   rd_en, rd_bank,
//   rd_addr, rd_data     synchronous read; rd_data holds when rd_en=0
//   wr_ready             fill bank is not full
//   overflow             sticky: a write was dropped
//   fill_bank            bank currently being filled
//   bank_full, bank_cnt  per-bank closed flag and spike count
// ---------------------------------------------------------------------------
module spike_pingpong_buf
    import fc_layer2_spike_scheduler_pkg::*;
#(
    parameter int DEPTH = SPK_DEPTH,
    parameter int IDX_W = SYNAPSE_INDEX_W,
    parameter int CNT_W = SPK_CNT_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic                      frame_end,
    input  logic                      rel_en,
    input  logic                      rel_bank,
    input  logic                      rd_en,
    input  logic                      rd_bank,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [IDX_W-1:0]          rd_data,
    output logic                      wr_ready,
    output logic                      overflow,
    output logic                      fill_bank,
    output logic [1:0]                bank_full,
    output logic [1:0][CNT_W-1:0]     bank_cnt
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [IDX_W-1:0] mem [2][DEPTH];
    logic             wr_accept;
    logic             close_bank;

    assign wr_ready   = ~bank_full[fill_bank];
    assign wr_accept  = wr_en && wr_ready && (bank_cnt[fill_bank] < CNT_W'(DEPTH));
    // A frame_end while both banks are full has no bank to close.
    assign close_bank = frame_end && wr_ready;

    // Storage carries no reset; only the counters/flags define validity.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[fill_bank][bank_cnt[fill_bank][ADDR_W-1:0]] <= wr_idx;
    end

    // The released bank is never the open fill bank, so release and write
    // never touch the same counter in one cycle.
    always_ff @(posedge clk) begin
        if (rstn) begin
            fill_bank <= 1'b0;
            bank_full <= '0;
            bank_cnt  <= '0;
            overflow  <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (wr_accept)
                bank_cnt[fill_bank] <= bank_cnt[fill_bank] + CNT_W'(1);
            else if (wr_en)
                overflow <= 1'b1;
            if (close_bank) begin
                bank_full[fill_bank] <= 1'b1;
                fill_bank            <= ~fill_bank;
            end
            if (rel_en) begin
                bank_full[rel_bank] <= 1'b0;
                bank_cnt[rel_bank]  <= '0;
            end
            if (rd_en)
                rd_data <= mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/fc_layer2_spike_scheduler.sv
// ---------------------------------------------------------------------------
// fc_layer2_spike_scheduler
// Ping-pong spike-index buffer plus issue sequencer for the layer-2 FC PE.
// A closed bank is replayed OUTPUT_CHANNEL_NUM times, one index per cycle,
// then held until the PE pipeline drains (PIPE_LAT) and released.
// Ports:
//   clk, rstn       clock, synchronous active-high reset
//   spk_wr_en/idx   spike write into the fill bank
//   spk_frame_end   close the fill bank (1-cycle pulse)
//   spk_wr_ready    a fill bank is available
//   s_index_ram     index to PE, valid with s_index_valid
//   addr_most       spike count of the active frame - 1
//   frame_done      1-cycle pulse when a bank is released
//   busy            sequencer not idle
//   spk_overflow    sticky dropped-write flag
// ---------------------------------------------------------------------------
module fc_layer2_spike_scheduler
    import fc_layer2_spike_scheduler_pkg::*;
#(
    parameter int INPUT_CHANNEL_NUM  = SPK_DEPTH,
    parameter int OUTPUT_CHANNEL_NUM = 256,
    parameter int PIPE_LAT           = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       spk_wr_en,
    input  logic [SYNAPSE_INDEX_W-1:0] spk_wr_idx,
    input  logic                       spk_frame_end,
    output logic                       spk_wr_ready,
    output logic [SYNAPSE_INDEX_W-1:0] s_index_ram,
    output logic [CONV1_ADDR_W-1:0]    addr_most,
    output logic                       s_index_valid,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       spk_overflow
);

    localparam int CNT_W  = SPK_CNT_W;
    localparam int ADDR_W = $clog2(INPUT_CHANNEL_NUM);
    localparam int CH_W   = $clog2(OUTPUT_CHANNEL_NUM + 1);
    localparam int DR_W   = $clog2(PIPE_LAT + 1);

    sch_state_e            state, state_nxt;
    logic                  rd_bank;
    logic [ADDR_W-1:0]     idx_cnt;
    logic [CH_W-1:0]       ch_cnt;
    logic [DR_W-1:0]       drain_cnt;
    logic                  fill_bank;
    logic [1:0]            bank_full;
    logic [1:0][CNT_W-1:0] bank_cnt;
    logic                  oldest;
    logic [CNT_W-1:0]      oldest_cnt;
    logic [CNT_W-1:0]      oldest_cnt_m1;
    logic                  start;
    logic                  last_idx;
    logic                  last_issue;

    // The bank not being filled is always the older of the two.
    assign oldest        = ~fill_bank;
    assign oldest_cnt    = bank_cnt[oldest];
    assign oldest_cnt_m1 = oldest_cnt - CNT_W'(1);
    assign start         = (state == SCH_IDLE) && bank_full[oldest];
    assign last_idx      = (idx_cnt == addr_most[ADDR_W-1:0]);
    assign last_issue    = last_idx && (ch_cnt == CH_W'(OUTPUT_CHANNEL_NUM - 1));
    assign busy          = (state != SCH_IDLE);
    assign frame_done    = (state == SCH_RELEASE);

    spike_pingpong_buf #(
        .DEPTH (INPUT_CHANNEL_NUM),
        .IDX_W (SYNAPSE_INDEX_W),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (spk_wr_en),
        .wr_idx    (spk_wr_idx),
        .frame_end (spk_frame_end),
        .rel_en    (state == SCH_RELEASE),
        .rel_bank  (rd_bank),
        .rd_en     (state == SCH_ISSUE),
        .rd_bank   (rd_bank),
        .rd_addr   (idx_cnt),
        .rd_data   (s_index_ram),
        .wr_ready  (spk_wr_ready),
        .overflow  (spk_overflow),
        .fill_bank (fill_bank),
        .bank_full (bank_full),
        .bank_cnt  (bank_cnt)
    );

    always_ff @(posedge clk) begin
        if (rstn) state <= SCH_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCH_IDLE:    if (start)
                             state_nxt = (oldest_cnt == '0) ? SCH_RELEASE : SCH_ISSUE;
            SCH_ISSUE:   if (last_issue) state_nxt = SCH_DRAIN;
            SCH_DRAIN:   if (drain_cnt == DR_W'(PIPE_LAT)) state_nxt = SCH_RELEASE;
            SCH_RELEASE: state_nxt = SCH_IDLE;
            default:     state_nxt = SCH_IDLE;
        endcase
    end

    // ---- issue counters: read address is presented in ISSUE, data/valid one cycle later
    always_ff @(posedge clk) begin
        if (rstn) begin
            rd_bank       <= 1'b0;
            idx_cnt       <= '0;
            ch_cnt        <= '0;
            drain_cnt     <= '0;
            addr_most     <= '0;
            s_index_valid <= 1'b0;
        end else begin
            s_index_valid <= (state == SCH_ISSUE);
            case (state)
                SCH_IDLE: begin
                    if (start) begin
                        rd_bank   <= oldest;
                        idx_cnt   <= '0;
                        ch_cnt    <= '0;
                        drain_cnt <= '0;
                        // An empty frame skips ISSUE, so addr_most keeps its last value.
                        if (oldest_cnt != '0)
                            addr_most <= CONV1_ADDR_W'(oldest_cnt_m1);
                    end
                end
                SCH_ISSUE: begin
                    if (last_idx) begin
                        idx_cnt <= '0;
                        ch_cnt  <= ch_cnt + CH_W'(1);
                    end else begin
                        idx_cnt <= idx_cnt + ADDR_W'(1);
                    end
                end
                SCH_DRAIN: drain_cnt <= drain_cnt + DR_W'(1);
                default: ;
            endcase
        end
    end

endmodule
